pwm_generator: RTL
==================

# pwm_generator

Fixed-period PWM engine that sits directly downstream of the sine duty-cycle LUT stage. It consumes the LUT's 32-bit duty value, latches it once per PWM period, and drives a complementary, dead-time-protected output pair. It also produces the one-clock period-end strobe `indexFlag` that advances the LUT to its next sample, which closes the loop between the two stages.

## Interface
- `CLK_DIV`, default 4: clock cycles per counter tick; valid range ≥1, where 1 means a tick on every clock.
- `PERIOD`, default 2500: ticks per PWM period. Also the full-scale duty value, since LUT values span 0–2499.
- `DEAD_TIME`, default 8: clocks with both outputs low on each output transition; 0 disables dead time.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run/stop control.
- `DutyIn`  in  32  unsigned duty in ticks, driven by the LUT stage's `DutyOut`.
- `pwmHigh`  out  1  high-side drive.
- `pwmLow`  out  1  low-side drive, the complement of `pwmHigh` with dead time inserted.
- `indexFlag`  out  1  one-clock pulse at each period wrap; drives the LUT stage's index input.
- `periodCount`  out  32  current tick count, 0..PERIOD-1.

## Operation
- **Prescaler** `div` counts 0..CLK_DIV-1 and asserts `tick` when `div==CLK_DIV-1`, then wraps to 0.
- **Period counter** `periodCount` advances on `tick`. A tick at `PERIOD-1` wraps it to 0; this is the **wrap** event.
- **Shadow duty register** `activeDuty`:
  - Loads `min(DutyIn, PERIOD)` on every wrap.
  - Loads continuously while `enable`=0.
  - Never changes mid-period.
- **Raw compare:** `rawReg <= (periodCount < activeDuty)`, registered.
  - Duty 0 keeps `rawReg`=0.
  - Duty ≥PERIOD keeps `rawReg`=1.
- **Period strobe:** `indexFlag` is registered high for exactly one clock, the clock after a wrap. The LUT stage updates `DutyIn` in response, and that value takes effect at the following wrap. This gives a fixed one-period duty pipeline.
- **Dead-time FSM** states are IDLE, LOW_ON, DEAD_TO_HIGH, HIGH_ON, DEAD_TO_LOW. Transitions:
  - IDLE → DEAD_TO_HIGH if `enable`&`rawReg`; IDLE → LOW_ON if `enable`&!`rawReg`.
  - LOW_ON → DEAD_TO_HIGH on `rawReg`=1.
  - HIGH_ON → DEAD_TO_LOW on `rawReg`=0.
  - DEAD_TO_HIGH → HIGH_ON after DEAD_TIME clocks. If `rawReg` drops first, it aborts to LOW_ON on the next clock.
  - DEAD_TO_LOW → LOW_ON after DEAD_TIME clocks. If `rawReg` rises first, it aborts to HIGH_ON on the next clock.
  - With DEAD_TIME=0 the dead states are bypassed: LOW_ON and HIGH_ON go directly to each other.
  - Any state → IDLE when `enable`=0.
- **Output decode** (registered):
  - `pwmHigh` is 1 only in HIGH_ON.
  - `pwmLow` is 1 only in LOW_ON.
  - Both are 0 in IDLE and in the dead states.
  - `pwmHigh`&`pwmLow` is never 1.
- **Disable** (`enable`=0):
  - `div`, `periodCount` and `indexFlag` are forced to 0.
  - Dead-time counter is cleared.
  - Both outputs go low on the next clock.
- **Re-enable:** the first period starts at count 0 using the `activeDuty` loaded while disabled. No `indexFlag` fires until the first wrap.
- **Dead-time counter:** 32-bit, cleared on every state entry.

## Timing
- **Reset values** on `rst` (asynchronous): `pwmHigh`=0, `pwmLow`=0, `indexFlag`=0, `periodCount`=0. Internally `div`=0, `activeDuty`=0, `rawReg`=0, state IDLE.
- **Reset mid-period:** outputs drop immediately, without waiting for a clock edge.
- **Count to raw:** `rawReg` lags `periodCount` by 1 clock.
- **Falling edge of `pwmLow`:** 1 clock after `rawReg` rises.
- **Rising edge of `pwmHigh`:** DEAD_TIME clocks after `pwmLow` falls. The opposite transition is symmetric.
- **Period length:** exactly CLK_DIV·PERIOD clocks, and `indexFlag` recurs at that spacing.
- **Simultaneous wrap and `DutyIn` change:** the value sampled at the wrap clock is the one used.
- **Simultaneous wrap and `enable` fall:** disable wins; no `indexFlag` is emitted.

## Structure
- **Shared package `pwm_pkg`:**
  - FSM state encoding: 3-bit localparams.
  - Default constants: `PWM_PERIOD`=2500, `PWM_CLK_DIV`=4, `PWM_DEAD_TIME`=8, `DUTY_W`=32.
  - Also imported by the LUT stage for full-scale consistency.
- **Sub-module `dead_time_gen`:** contains the FSM, the dead-time counter and the output registers. Inputs are `clk`, `rst`, `enable` and `rawReg`.
- **Top level:** prescaler, period counter, shadow register, compare and strobe.

## Test plan
Directed scenarios use CLK_DIV=1, PERIOD=10, DEAD_TIME=2 unless noted.
- **Reset/enable:** hold `rst` for 3 clocks, then enable with `DutyIn`=4 → outputs stay 0 during reset. Once enabled, `pwmHigh` is high 4−2=2 clocks per period, `indexFlag` pulses every 10 clocks, and `pwmHigh`&`pwmLow` is never 1.
- **Extremes:** `DutyIn`=0 → `pwmLow` held 1 and `pwmHigh` held 0 in steady state. `DutyIn`=2499 with PERIOD=10 → clamped to 10, so `pwmHigh` is held 1.
- **Duty pipeline:** change `DutyIn` 3→7 in the clock after `indexFlag` → the next period still uses 3 and the period after uses 7. No mid-period change occurs.
- **Dead-time abort:** `DutyIn`=1 with DEAD_TIME=2 → FSM enters DEAD_TO_HIGH, aborts back to LOW_ON, and `pwmHigh` never asserts.
- **Prescale:** CLK_DIV=4, PERIOD=10 → `indexFlag` spacing is exactly 40 clocks, and `periodCount` holds each value for 4 clocks.
- **Mid-period disturbance:**
  - Assert `rst` asynchronously mid-period → outputs go to 0 before the next clock edge.
  - Drop `enable` on the wrap clock → no `indexFlag` is emitted and both outputs are low on the next clock.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and duty clamp for the sine-LUT / PWM pair.
// Also imported by the LUT stage so both agree on full scale.
package pwm_pkg;

    localparam int PWM_PERIOD    = 2500;
    localparam int PWM_CLK_DIV   = 4;
    localparam int PWM_DEAD_TIME = 8;
    localparam int DUTY_W        = 32;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_LOW_ON       = 3'd1;
    localparam logic [2:0] ST_DEAD_TO_HIGH = 3'd2;
    localparam logic [2:0] ST_HIGH_ON      = 3'd3;
    localparam logic [2:0] ST_DEAD_TO_LOW  = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        LOW_ON       = ST_LOW_ON,
        DEAD_TO_HIGH = ST_DEAD_TO_HIGH,
        HIGH_ON      = ST_HIGH_ON,
        DEAD_TO_LOW  = ST_DEAD_TO_LOW
    } dt_state_e;

    // LUT values may exceed the period; anything above full scale means always-high.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                     input logic [DUTY_W-1:0] full_scale);
        logic [DUTY_W-1:0] res;
        if (duty > full_scale) begin
            res = full_scale;
        end else begin
            res = duty;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// Control/status bundle between the PWM engine and its driver (LUT stage or bench).
interface pwm_generator_if;
    import pwm_pkg::*;

    logic              enable;
    logic [DUTY_W-1:0] DutyIn;
    logic              pwmHigh;
    logic              pwmLow;
    logic              indexFlag;
    logic [DUTY_W-1:0] periodCount;

    modport master (
        output enable,
        output DutyIn,
        input  pwmHigh,
        input  pwmLow,
        input  indexFlag,
        input  periodCount
    );

    modport slave (
        input  enable,
        input  DutyIn,
        output pwmHigh,
        output pwmLow,
        output indexFlag,
        output periodCount
    );

endinterface

// File: rtl/dead_time_gen.sv
// Complementary output pair with break-before-make dead time driven by the raw compare.
// An aborted dead interval returns to the side it came from without ever driving the other.
module dead_time_gen
    import pwm_pkg::*;
#(
    parameter int DEAD_TIME = PWM_DEAD_TIME
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic rawReg,
    output logic pwmHigh,
    output logic pwmLow
);

    localparam bit          DT_BYPASS = (DEAD_TIME == 0);
    localparam logic [31:0] DT_LAST   = (DEAD_TIME > 0) ? 32'(DEAD_TIME - 1) : 32'd0;

    dt_state_e   state_r;
    dt_state_e   next_state_s;
    logic [31:0] dt_cnt_r;
    logic        dt_done_s;
    logic        in_dead_s;

    assign dt_done_s = (dt_cnt_r >= DT_LAST);
    assign in_dead_s = (state_r == DEAD_TO_HIGH) || (state_r == DEAD_TO_LOW);

    // Next-state logic; abort on raw reversal takes priority over dead-time expiry.
    always_comb begin
        next_state_s = state_r;
        if (!enable) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, LOW_ON: begin
                    if (rawReg) begin
                        if (DT_BYPASS) begin
                            next_state_s = HIGH_ON;
                        end else begin
                            next_state_s = DEAD_TO_HIGH;
                        end
                    end else begin
                        next_state_s = LOW_ON;
                    end
                end
                DEAD_TO_HIGH: begin
                    if (!rawReg) begin
                        next_state_s = LOW_ON;
                    end else if (dt_done_s) begin
                        next_state_s = HIGH_ON;
                    end else begin
                        next_state_s = DEAD_TO_HIGH;
                    end
                end
                HIGH_ON: begin
                    if (!rawReg) begin
                        if (DT_BYPASS) begin
                            next_state_s = LOW_ON;
                        end else begin
                            next_state_s = DEAD_TO_LOW;
                        end
                    end else begin
                        next_state_s = HIGH_ON;
                    end
                end
                DEAD_TO_LOW: begin
                    if (rawReg) begin
                        next_state_s = HIGH_ON;
                    end else if (dt_done_s) begin
                        next_state_s = LOW_ON;
                    end else begin
                        next_state_s = DEAD_TO_LOW;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Dead-time counter: restarts on every state entry, advances only inside a dead interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_cnt_r <= 32'd0;
        end else if (!enable || (next_state_s != state_r)) begin
            dt_cnt_r <= 32'd0;
        end else if (in_dead_s) begin
            dt_cnt_r <= dt_cnt_r + 32'd1;
        end else begin
            dt_cnt_r <= dt_cnt_r;
        end
    end

    // Outputs decoded from the next state so they stay aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmHigh <= 1'b0;
            pwmLow  <= 1'b0;
        end else begin
            pwmHigh <= (next_state_s == HIGH_ON);
            pwmLow  <= (next_state_s == LOW_ON);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM engine: prescaler, period counter, shadowed duty, compare and period strobe.
// indexFlag advances the upstream LUT, whose new value is latched at the following wrap.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CLK_DIV   = PWM_CLK_DIV,
    parameter int PERIOD    = PWM_PERIOD,
    parameter int DEAD_TIME = PWM_DEAD_TIME
) (
    input  logic            clk,
    input  logic            rst,
    pwm_generator_if.slave  bus
);

    localparam logic [DUTY_W-1:0] DIV_LAST    = DUTY_W'(CLK_DIV - 1);
    localparam logic [DUTY_W-1:0] PERIOD_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] FULL_SCALE  = DUTY_W'(PERIOD);

    logic [DUTY_W-1:0] div_r;
    logic [DUTY_W-1:0] period_count_r;
    logic [DUTY_W-1:0] active_duty_r;
    logic [DUTY_W-1:0] clamped_duty_s;
    logic              raw_reg_r;
    logic              index_flag_r;
    logic              tick_s;
    logic              wrap_s;
    logic              pwm_high_s;
    logic              pwm_low_s;

    assign tick_s         = bus.enable && (div_r == DIV_LAST);
    assign wrap_s         = tick_s && (period_count_r == PERIOD_LAST);
    assign clamped_duty_s = clamp_duty(bus.DutyIn, FULL_SCALE);

    // Clock prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= 32'd0;
        end else if (!bus.enable) begin
            div_r <= 32'd0;
        end else if (tick_s) begin
            div_r <= 32'd0;
        end else begin
            div_r <= div_r + 32'd1;
        end
    end

    // Period counter and wrap strobe; disable suppresses a coincident wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_count_r <= 32'd0;
            index_flag_r   <= 1'b0;
        end else if (!bus.enable) begin
            period_count_r <= 32'd0;
            index_flag_r   <= 1'b0;
        end else begin
            index_flag_r <= wrap_s;
            if (wrap_s) begin
                period_count_r <= 32'd0;
            end else if (tick_s) begin
                period_count_r <= period_count_r + 32'd1;
            end else begin
                period_count_r <= period_count_r;
            end
        end
    end

    // Shadow duty: tracks the input while stopped, otherwise only updates at a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty_r <= 32'd0;
        end else if (!bus.enable || wrap_s) begin
            active_duty_r <= clamped_duty_s;
        end else begin
            active_duty_r <= active_duty_r;
        end
    end

    // Raw compare, one clock behind the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_reg_r <= 1'b0;
        end else begin
            raw_reg_r <= (period_count_r < active_duty_r);
        end
    end

    dead_time_gen #(
        .DEAD_TIME (DEAD_TIME)
    ) u_dead_time (
        .clk     (clk),
        .rst     (rst),
        .enable  (bus.enable),
        .rawReg  (raw_reg_r),
        .pwmHigh (pwm_high_s),
        .pwmLow  (pwm_low_s)
    );

    assign bus.pwmHigh     = pwm_high_s;
    assign bus.pwmLow      = pwm_low_s;
    assign bus.indexFlag   = index_flag_r;
    assign bus.periodCount = period_count_r;

endmodule
